// File: rtl/core_lsu.sv
// core_lsu: MEMORY-stage load/store unit between EXECUTE and WRITEBACK.
// Accepts one decoded load/store with its effective address and store data,
// runs a single req/ack transfer on the data-memory port, steers little-endian
// byte lanes, sign/zero-extends loads and reports completion with a DONE pulse.
// Optional feature macro: CORE_LSU_MISALIGN_EN. When defined, misaligned
// halfword/word accesses complete immediately with ERR and never touch memory.
// When undefined, halfwords ignore ADDR[0] and words ignore ADDR[1:0].
//
// Memory handshake: MEM_REQ rises the cycle after an accepted START and holds
// MEM_ADDR/MEM_WE/MEM_BE/MEM_WDATA stable until the transfer ends. A transfer
// completes on any rising edge where MEM_REQ=1 and MEM_ACK=1 (MEM_RDATA sampled
// on that edge); MEM_ACK while MEM_REQ=0 has no effect. If TIMEOUT_CYCLES is
// non-zero and that many request cycles pass without ack, MEM_REQ drops and the
// op finishes with ERR.
module core_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        I_LB,
  input  logic        I_LH,
  input  logic        I_LW,
  input  logic        I_LBU,
  input  logic        I_LHU,
  input  logic        I_SB,
  input  logic        I_SH,
  input  logic        I_SW,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] LOAD_DATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic [1:0]  DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  state_e          state_q;
  state_e          state_d;
  logic [TO_W-1:0] to_cnt_q;

  // Decoded op
  logic            op_any;
  logic            op_we;
  logic            op_sgn;
  size_e           op_sz;
  logic [3:0]      op_be;
  logic [31:0]     op_wdata;
  logic            op_misalign;

  // Latched op attributes needed when the read data returns
  size_e           sz_q;
  logic            sgn_q;
  logic [1:0]      lane_q;
  logic            err_q;
  logic [31:0]     ld_q;

  logic            accept;
  logic            to_hit;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [31:0]     ld_ext;

  // Priority decode of the op bits: LW > LH > LHU > LB > LBU > SW > SH > SB
  always_comb begin
    op_any = 1'b1;
    op_we  = 1'b0;
    op_sgn = 1'b0;
    op_sz  = SZ_W;
    if (I_LW) begin
      op_sz = SZ_W;
    end else if (I_LH) begin
      op_sz  = SZ_H;
      op_sgn = 1'b1;
    end else if (I_LHU) begin
      op_sz = SZ_H;
    end else if (I_LB) begin
      op_sz  = SZ_B;
      op_sgn = 1'b1;
    end else if (I_LBU) begin
      op_sz = SZ_B;
    end else if (I_SW) begin
      op_sz = SZ_W;
      op_we = 1'b1;
    end else if (I_SH) begin
      op_sz = SZ_H;
      op_we = 1'b1;
    end else if (I_SB) begin
      op_sz = SZ_B;
      op_we = 1'b1;
    end else begin
      op_any = 1'b0;
    end
  end

  // Byte enables and lane-replicated store data for the decoded size
  always_comb begin
    op_be    = 4'b1111;
    op_wdata = WDATA;
    case (op_sz)
      SZ_B: begin
        op_be    = 4'b0001 << ADDR[1:0];
        op_wdata = {4{WDATA[7:0]}};
      end
      SZ_H: begin
        op_be    = ADDR[1] ? 4'b1100 : 4'b0011;
        op_wdata = {2{WDATA[15:0]}};
      end
      default: begin
        op_be    = 4'b1111;
        op_wdata = WDATA;
      end
    endcase
  end

`ifdef CORE_LSU_MISALIGN_EN
  assign op_misalign = ((op_sz == SZ_H) && ADDR[0]) ||
                       ((op_sz == SZ_W) && (ADDR[1:0] != 2'b00));
`else
  assign op_misalign = 1'b0;
`endif

  assign accept = (state_q == S_IDLE) && START && op_any;

  // An ack on the limit cycle wins over the timeout
  assign to_hit = (TIMEOUT_CYCLES != 0) && (state_q == S_REQ) && !MEM_ACK &&
                  ((to_cnt_q + TO_W'(1)) == TO_LIMIT);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    MEM_REQ   = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    ERR       = 1'b0;
    LOAD_DATA = 32'h0;
    DBG_STATE = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = op_misalign ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        MEM_REQ = 1'b1;
        BUSY    = 1'b1;
        if (MEM_ACK || to_hit) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        BUSY      = 1'b1;
        DONE      = 1'b1;
        ERR       = err_q;
        LOAD_DATA = ld_q;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Timeout counter: cleared on REQ entry, counts request cycles without ack
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      to_cnt_q <= '0;
    end else if (accept) begin
      to_cnt_q <= '0;
    end else if ((state_q == S_REQ) && !MEM_ACK) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // Lane selection and extension of the returned read word
  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = MEM_RDATA[7:0];
      2'd1:    rd_byte = MEM_RDATA[15:8];
      2'd2:    rd_byte = MEM_RDATA[23:16];
      default: rd_byte = MEM_RDATA[31:24];
    endcase
    rd_half = lane_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    case (sz_q)
      SZ_B:    ld_ext = sgn_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      SZ_H:    ld_ext = sgn_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
      default: ld_ext = MEM_RDATA;
    endcase
  end

  // Memory-port fields and op attributes latched at START; result captured on ack
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MEM_ADDR  <= 32'h0;
      MEM_WE    <= 1'b0;
      MEM_BE    <= 4'h0;
      MEM_WDATA <= 32'h0;
      sz_q      <= SZ_B;
      sgn_q     <= 1'b0;
      lane_q    <= 2'b00;
      err_q     <= 1'b0;
      ld_q      <= 32'h0;
    end else begin
      if (accept) begin
        MEM_ADDR  <= {ADDR[31:2], 2'b00};
        MEM_WE    <= op_we;
        MEM_BE    <= op_be;
        MEM_WDATA <= op_wdata;
        sz_q      <= op_sz;
        sgn_q     <= op_sgn;
        lane_q    <= ADDR[1:0];
        err_q     <= op_misalign;
        ld_q      <= 32'h0;
      end
      if (state_q == S_REQ) begin
        if (MEM_ACK) begin
          ld_q <= MEM_WE ? 32'h0 : ld_ext;
        end else if (to_hit) begin
          err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: directed vector table, hand-written corner sequences and a
// randomized run for core_lsu, checked against a byte-arithmetic model of the
// load/store rules. The DUT is built with an 8-cycle ack timeout.
module tb_core_lsu;

  localparam int TB_TO = 8;
  localparam int EXP_W = 110;

  // Op mask bit positions: {LW, LH, LHU, LB, LBU, SW, SH, SB}
  localparam logic [7:0] M_LW  = 8'h80;
  localparam logic [7:0] M_LH  = 8'h40;
  localparam logic [7:0] M_LHU = 8'h20;
  localparam logic [7:0] M_LB  = 8'h10;
  localparam logic [7:0] M_LBU = 8'h08;
  localparam logic [7:0] M_SW  = 8'h04;
  localparam logic [7:0] M_SH  = 8'h02;
  localparam logic [7:0] M_SB  = 8'h01;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int total;
  int bad;

  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    logic [7:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    bit          poke;
    int          e_req;
    logic        e_err;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_ld;
  } vec_t;

  vec_t vecs[16];

  core_lsu #(
    .TIMEOUT_CYCLES(TB_TO),
    .TO_W(8)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .START(start),
    .I_LB(i_lb),
    .I_LH(i_lh),
    .I_LW(i_lw),
    .I_LBU(i_lbu),
    .I_LHU(i_lhu),
    .I_SB(i_sb),
    .I_SH(i_sh),
    .I_SW(i_sw),
    .ADDR(addr),
    .WDATA(wdata),
    .BUSY(busy),
    .DONE(done),
    .ERR(err),
    .LOAD_DATA(load_data),
    .MEM_REQ(mem_req),
    .MEM_WE(mem_we),
    .MEM_BE(mem_be),
    .MEM_ADDR(mem_addr),
    .MEM_WDATA(mem_wdata),
    .MEM_ACK(mem_ack),
    .MEM_RDATA(mem_rdata),
    .DBG_STATE(dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [7:0] mask);
    {i_lw, i_lh, i_lhu, i_lb, i_lbu, i_sw, i_sh, i_sb} = mask;
  endtask

  // Reference model: expected transaction from the op rules, using byte counts and shifts.
  // Packing: {req_cycles[7:0], err, we, be[3:0], wdata[31:0], load[31:0], word_addr[31:0]}
  function automatic logic [EXP_W-1:0] model(input logic [7:0] mask, input logic [31:0] a,
                                             input logic [31:0] wd_in, input logic [31:0] rd,
                                             input int stall);
    int          nbytes;
    int          off;
    int          req;
    bit          sgn;
    logic        we;
    logic        e;
    bit          misal;
    logic [31:0] be;
    logic [31:0] wd;
    logic [31:0] val;
    logic [31:0] ld;
    nbytes = 4;
    sgn    = 1'b0;
    we     = 1'b0;
    if (mask[7])      begin nbytes = 4; end
    else if (mask[6]) begin nbytes = 2; sgn = 1'b1; end
    else if (mask[5]) begin nbytes = 2; end
    else if (mask[4]) begin nbytes = 1; sgn = 1'b1; end
    else if (mask[3]) begin nbytes = 1; end
    else if (mask[2]) begin nbytes = 4; we = 1'b1; end
    else if (mask[1]) begin nbytes = 2; we = 1'b1; end
    else              begin nbytes = 1; we = 1'b1; end
    if (nbytes == 4)      off = 0;
    else if (nbytes == 2) off = 2 * int'(a[1]);
    else                  off = int'(a[1:0]);
    be = ((32'd1 << nbytes) - 32'd1) << off;
    if (nbytes == 1)      wd = {24'h0, wd_in[7:0]} * 32'h0101_0101;
    else if (nbytes == 2) wd = {16'h0, wd_in[15:0]} * 32'h0001_0001;
    else                  wd = wd_in;
    val = rd >> (8 * off);
    if (nbytes < 4) begin
      val = val & ((32'd1 << (8 * nbytes)) - 32'd1);
      if (sgn && (val >= (32'd1 << (8 * nbytes - 1)))) val = val - (32'd1 << (8 * nbytes));
    end
    misal = 1'b0;
`ifdef CORE_LSU_MISALIGN_EN
    misal = ((nbytes == 2) && a[0]) || ((nbytes == 4) && (a[1:0] != 2'b00));
`endif
    if (misal) begin
      req = 0;
      e   = 1'b1;
    end else if (stall < TB_TO) begin
      req = stall + 1;
      e   = 1'b0;
    end else begin
      req = TB_TO;
      e   = 1'b1;
    end
    ld = (we || e) ? 32'h0 : val;
    return {8'(req), e, we, be[3:0], wd, ld, {a[31:2], 2'b00}};
  endfunction

  // Driver: issue one op, act as memory (ack after 'stall' request cycles), collect results.
  // With poke set, a store START is thrown at the DUT mid-request to prove it is ignored.
  task automatic run_op(input logic [7:0] mask, input logic [31:0] a, input logic [31:0] wd_in,
                        input logic [31:0] rd, input int stall, input bit poke,
                        output int req_cyc, output int lat, output bit done_seen,
                        output logic r_err, output logic [31:0] r_ld, output logic [3:0] r_be,
                        output logic r_we, output logic [31:0] r_addr, output logic [31:0] r_wd,
                        output bit hold_bad);
    int cyc;
    req_cyc   = 0;
    lat       = 0;
    done_seen = 1'b0;
    r_err     = 1'b0;
    r_ld      = 32'h0;
    r_be      = 4'h0;
    r_we      = 1'b0;
    r_addr    = 32'h0;
    r_wd      = 32'h0;
    hold_bad  = 1'b0;
    @(negedge clk);
    drive_op(mask);
    start = 1'b1;
    addr  = a;
    wdata = wd_in;
    @(negedge clk);
    start = 1'b0;
    drive_op(8'h00);
    addr  = $urandom;
    wdata = $urandom;
    cyc   = 1;
    while ((cyc < 64) && !done_seen) begin
      start = 1'b0;
      drive_op(8'h00);
      if (done) begin
        done_seen = 1'b1;
        lat       = cyc;
        r_err     = err;
        r_ld      = load_data;
        mem_ack   = 1'b0;
      end else begin
        mem_ack = 1'b0;
        if (mem_req) begin
          if (req_cyc == 0) begin
            r_be   = mem_be;
            r_we   = mem_we;
            r_addr = mem_addr;
            r_wd   = mem_wdata;
          end else if ((mem_be !== r_be) || (mem_we !== r_we) ||
                       (mem_addr !== r_addr) || (mem_wdata !== r_wd)) begin
            hold_bad = 1'b1;
          end
          if (busy !== 1'b1) hold_bad = 1'b1;
          if (req_cyc == stall) begin
            mem_ack   = 1'b1;
            mem_rdata = rd;
          end else begin
            mem_rdata = $urandom;
          end
          if (poke && (req_cyc == 2)) begin
            drive_op(M_SW);
            start = 1'b1;
            addr  = 32'h0000_0FF1;
          end
          req_cyc++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    mem_ack = 1'b0;
    start   = 1'b0;
    drive_op(8'h00);
  endtask

  // Scoreboard: compare one completed op against the front of the expected queue
  task automatic run_and_check(input string tag, input logic [7:0] mask, input logic [31:0] a,
                               input logic [31:0] wd_in, input logic [31:0] rd,
                               input int stall, input bit poke);
    int               req_cyc, lat;
    bit               done_seen, hold_bad, idle_bad;
    logic             r_err, r_we;
    logic [31:0]      r_ld, r_addr, r_wd;
    logic [3:0]       r_be;
    logic [EXP_W-1:0] e;
    int               e_req;
    run_op(mask, a, wd_in, rd, stall, poke, req_cyc, lat, done_seen, r_err, r_ld, r_be, r_we,
           r_addr, r_wd, hold_bad);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s.exp_q: got empty queue want an entry", tag);
    end else begin
      e     = exp_q.pop_front();
      e_req = int'(e[109:102]);
      check({tag, ".done"}, 32'(done_seen), 32'd1);
      check({tag, ".req_cycles"}, 32'(req_cyc), 32'(e_req));
      check({tag, ".latency"}, 32'(lat), 32'(e_req + 1));
      check({tag, ".err"}, 32'(r_err), 32'(e[101]));
      check({tag, ".load_data"}, r_ld, e[63:32]);
      if (e_req != 0) begin
        check({tag, ".we"}, 32'(r_we), 32'(e[100]));
        check({tag, ".be"}, 32'(r_be), 32'(e[99:96]));
        check({tag, ".mem_addr"}, r_addr, e[31:0]);
        check({tag, ".hold"}, 32'(hold_bad), 32'd0);
        if (e[100]) check({tag, ".mem_wdata"}, r_wd, e[95:64]);
      end
    end
    // DONE is a single pulse and nothing follows (no queued START)
    idle_bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done || mem_req || busy) idle_bad = 1'b1;
    end
    check({tag, ".idle_after"}, 32'(idle_bad), 32'd0);
  endtask

  initial begin
    bit          flag;
    logic [7:0]  rmask;
    logic [31:0] ra, rw, rr;
    int          rs;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    drive_op(8'h00);
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;

    // Directed table: mask, addr, wdata, rdata, stall, poke, req, err, we, be, wdata, load
    vecs[0]  = '{M_SW,  32'h100, 32'hDEADBEEF, 32'h0,        0, 1'b0, 1, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{M_SB,  32'h103, 32'h000000A5, 32'h0,        0, 1'b0, 1, 1'b0, 1'b1, 4'h8, 32'hA5A5A5A5, 32'h0};
    vecs[2]  = '{M_LB,  32'h202, 32'h0,        32'h12805634, 0, 1'b0, 1, 1'b0, 1'b0, 4'h4, 32'h0, 32'hFFFFFF80};
    vecs[3]  = '{M_LBU, 32'h202, 32'h0,        32'h12805634, 0, 1'b0, 1, 1'b0, 1'b0, 4'h4, 32'h0, 32'h00000080};
    vecs[4]  = '{M_LH,  32'h202, 32'h0,        32'h8001FFFF, 5, 1'b0, 6, 1'b0, 1'b0, 4'hC, 32'h0, 32'hFFFF8001};
    vecs[5]  = '{M_LHU, 32'h200, 32'h0,        32'h8001FFFF, 1, 1'b0, 2, 1'b0, 1'b0, 4'h3, 32'h0, 32'h0000FFFF};
    vecs[6]  = '{M_LW,  32'h300, 32'h0,        32'hCAFEF00D, 2, 1'b0, 3, 1'b0, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D};
    vecs[7]  = '{M_SH,  32'h306, 32'h1234ABCD, 32'h0,        3, 1'b0, 4, 1'b0, 1'b1, 4'hC, 32'hABCDABCD, 32'h0};
    vecs[8]  = '{M_LB,  32'h201, 32'h0,        32'h00007F00, 7, 1'b0, 8, 1'b0, 1'b0, 4'h2, 32'h0, 32'h0000007F};
    vecs[9]  = '{M_LW,  32'h400, 32'h0,        32'h55555555, 8, 1'b1, 8, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0};
    vecs[10] = '{M_SB,  32'h200, 32'hFFFFFF3C, 32'h0,        0, 1'b0, 1, 1'b0, 1'b1, 4'h1, 32'h3C3C3C3C, 32'h0};
    vecs[11] = '{M_LB | M_SW,  32'h201, 32'h0, 32'h0000FE00, 0, 1'b0, 1, 1'b0, 1'b0, 4'h2, 32'h0, 32'hFFFFFFFE};
    vecs[12] = '{M_LH | M_LHU, 32'h200, 32'h0, 32'h00009000, 0, 1'b0, 1, 1'b0, 1'b0, 4'h3, 32'h0, 32'hFFFF9000};
`ifdef CORE_LSU_MISALIGN_EN
    vecs[13] = '{M_LH,  32'h203, 32'h0,        32'h7FFF0000, 0, 1'b0, 0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[14] = '{M_LW,  32'h101, 32'h0,        32'h11223344, 0, 1'b0, 0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[15] = '{M_SH,  32'h101, 32'h0000BEEF, 32'h0,        0, 1'b0, 0, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0};
`else
    vecs[13] = '{M_LH,  32'h203, 32'h0,        32'h7FFF0000, 0, 1'b0, 1, 1'b0, 1'b0, 4'hC, 32'h0, 32'h00007FFF};
    vecs[14] = '{M_LW,  32'h101, 32'h0,        32'h11223344, 0, 1'b0, 1, 1'b0, 1'b0, 4'hF, 32'h0, 32'h11223344};
    vecs[15] = '{M_SH,  32'h101, 32'h0000BEEF, 32'h0,        0, 1'b0, 1, 1'b0, 1'b1, 4'h3, 32'hBEEFBEEF, 32'h0};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.load_data", load_data, 32'h0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_be", 32'(mem_be), 32'd0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_wdata", mem_wdata, 32'h0);
    check("rst.state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // START with no op bit, and MEM_ACK with no request: both ignored
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    mem_ack = 1'b1;
    flag    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy || mem_req || done) flag = 1'b1;
    end
    mem_ack = 1'b0;
    check("noop_start_idle", 32'(flag), 32'd0);

    // Directed vectors; expectations come from the table
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({8'(vecs[i].e_req), vecs[i].e_err, vecs[i].e_we, vecs[i].e_be,
                       vecs[i].e_wd, vecs[i].e_ld, {vecs[i].addr[31:2], 2'b00}});
      run_and_check($sformatf("vec%0d", i), vecs[i].mask, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdata, vecs[i].stall, vecs[i].poke);
    end

    // Reset while a request is outstanding: MEM_REQ drops at once, no DONE follows
    @(negedge clk);
    drive_op(M_LW);
    start = 1'b1;
    addr  = 32'h500;
    @(negedge clk);
    start = 1'b0;
    drive_op(8'h00);
    @(negedge clk);
    check("midrst.req_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.req", 32'(mem_req), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    flag  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || mem_req) flag = 1'b1;
    end
    check("midrst.no_done", 32'(flag), 32'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) rmask = 8'($urandom_range(1, 255));
      else                           rmask = 8'(1 << $urandom_range(0, 7));
      ra = $urandom;
      rw = $urandom;
      rr = $urandom;
      rs = int'($urandom_range(0, 10));
      exp_q.push_back(model(rmask, ra, rw, rr, rs));
      run_and_check($sformatf("rnd%0d", i), rmask, ra, rw, rr, rs, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
